// File: rtl/row_cache_ctrl.sv
// Row cache controller: direct-mapped tag store sitting between a bank FSM
// and memory. Handles hit/miss resolution, dirty write-back, line allocation
// and a full-cache flush, and keeps saturating hit/miss statistics.
module row_cache_ctrl #(
    parameter int  ROW_BITS = 17,
    parameter int  SETS     = 32,
    parameter int  CNT_W    = 16,
    localparam int IDX_W    = $clog2(SETS),
    localparam int TAG_W    = ROW_BITS - IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RD,
    input  logic                WR,
    input  logic [ROW_BITS-1:0] RowId,
    input  logic                sync,
    input  logic                flush,
    output logic [IDX_W-1:0]    cRowId,
    output logic                ready,
    output logic                hold,
    output logic                memRd,
    output logic                memWr,
    output logic [ROW_BITS-1:0] memRowId,
    output logic                flushDone,
    output logic [CNT_W-1:0]    hitCnt,
    output logic [CNT_W-1:0]    missCnt
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CMP        = 3'd1,
        S_HIT_RD     = 3'd2,
        S_HIT_WR     = 3'd3,
        S_WB         = 3'd4,
        S_ALLOC      = 3'd5,
        S_FLUSH      = 3'd6,
        S_FLUSH_WAIT = 3'd7
    } state_t;

    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(SETS - 1);
    localparam logic [IDX_W-1:0] PTR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Tag store
    logic [SETS-1:0]       valid_r;
    logic [SETS-1:0]       dirty_r;
    logic [TAG_W-1:0]      tag_r [SETS];

    // Control state
    state_t                state_r;
    logic [ROW_BITS-1:0]   req_row_r;
    logic                  req_rd_r;
    logic                  missed_r;
    logic [IDX_W-1:0]      ptr_r;

    // Next-state and per-cycle actions
    state_t                state_next_s;
    logic [ROW_BITS-1:0]   req_row_next_s;
    logic                  req_rd_next_s;
    logic [IDX_W-1:0]      ptr_next_s;
    logic                  new_req_s;
    logic                  hit_evt_s;
    logic                  miss_evt_s;
    logic                  set_dirty_s;
    logic                  wb_done_s;
    logic                  fill_s;
    logic                  flush_clr_s;

    // Decoded output values, registered below
    logic                  ready_s;
    logic                  hold_s;
    logic                  mem_rd_s;
    logic                  mem_wr_s;
    logic [ROW_BITS-1:0]   mem_row_s;
    logic [IDX_W-1:0]      c_row_s;
    logic                  flush_done_s;

    logic [IDX_W-1:0]      req_idx_s;
    logic [TAG_W-1:0]      req_tag_s;
    logic [IDX_W-1:0]      req_idx_next_s;
    logic                  hit_s;

    assign req_idx_s      = req_row_r[IDX_W-1:0];
    assign req_tag_s      = req_row_r[ROW_BITS-1:IDX_W];
    assign req_idx_next_s = req_row_next_s[IDX_W-1:0];
    assign hit_s          = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);

    // Next-state logic: only the latched request drives the tag compare
    always_comb begin
        state_next_s   = state_r;
        req_row_next_s = req_row_r;
        req_rd_next_s  = req_rd_r;
        ptr_next_s     = ptr_r;
        new_req_s      = 1'b0;
        hit_evt_s      = 1'b0;
        miss_evt_s     = 1'b0;
        set_dirty_s    = 1'b0;
        wb_done_s      = 1'b0;
        fill_s         = 1'b0;
        flush_clr_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (RD || WR) begin
                    state_next_s   = S_CMP;
                    req_row_next_s = RowId;
                    req_rd_next_s  = RD;
                    new_req_s      = 1'b1;
                end else if (flush) begin
                    state_next_s = S_FLUSH;
                    ptr_next_s   = {IDX_W{1'b0}};
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CMP: begin
                if (hit_s) begin
                    hit_evt_s = 1'b1;
                    if (req_rd_r) begin
                        state_next_s = S_HIT_RD;
                    end else begin
                        state_next_s = S_HIT_WR;
                        set_dirty_s  = 1'b1;
                    end
                end else begin
                    miss_evt_s = 1'b1;
                    if (dirty_r[req_idx_s]) begin
                        state_next_s = S_WB;
                    end else begin
                        state_next_s = S_ALLOC;
                    end
                end
            end
            S_HIT_RD: begin
                if (!RD) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_HIT_RD;
                end
            end
            S_HIT_WR: begin
                if (!WR) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_HIT_WR;
                end
            end
            S_WB: begin
                if (sync) begin
                    state_next_s = S_ALLOC;
                    wb_done_s    = 1'b1;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_ALLOC: begin
                if (sync) begin
                    state_next_s = S_CMP;
                    fill_s       = 1'b1;
                end else begin
                    state_next_s = S_ALLOC;
                end
            end
            S_FLUSH: begin
                if (dirty_r[ptr_r]) begin
                    state_next_s = S_FLUSH_WAIT;
                end else if (ptr_r == PTR_LAST) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_FLUSH;
                    ptr_next_s   = ptr_r + PTR_ONE;
                end
            end
            S_FLUSH_WAIT: begin
                if (sync) begin
                    flush_clr_s = 1'b1;
                    if (ptr_r == PTR_LAST) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_FLUSH;
                        ptr_next_s   = ptr_r + PTR_ONE;
                    end
                end else begin
                    state_next_s = S_FLUSH_WAIT;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it
    always_comb begin
        ready_s      = 1'b0;
        hold_s       = 1'b0;
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        mem_row_s    = {ROW_BITS{1'b0}};
        c_row_s      = {IDX_W{1'b0}};
        flush_done_s = ((state_r == S_FLUSH) || (state_r == S_FLUSH_WAIT)) &&
                       (state_next_s == S_IDLE);
        case (state_next_s)
            S_CMP: begin
                c_row_s = req_idx_next_s;
            end
            S_HIT_RD, S_HIT_WR: begin
                c_row_s = req_idx_next_s;
                ready_s = 1'b1;
            end
            S_WB: begin
                c_row_s   = req_idx_next_s;
                hold_s    = 1'b1;
                mem_wr_s  = 1'b1;
                mem_row_s = {tag_r[req_idx_next_s], req_idx_next_s};
            end
            S_ALLOC: begin
                c_row_s   = req_idx_next_s;
                hold_s    = 1'b1;
                mem_rd_s  = 1'b1;
                mem_row_s = req_row_next_s;
            end
            S_FLUSH: begin
                hold_s = 1'b1;
            end
            S_FLUSH_WAIT: begin
                hold_s    = 1'b1;
                mem_wr_s  = 1'b1;
                mem_row_s = {tag_r[ptr_next_s], ptr_next_s};
            end
            default: begin
                c_row_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, tag store, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            req_row_r <= {ROW_BITS{1'b0}};
            req_rd_r  <= 1'b0;
            missed_r  <= 1'b0;
            ptr_r     <= {IDX_W{1'b0}};
            valid_r   <= {SETS{1'b0}};
            dirty_r   <= {SETS{1'b0}};
            for (int i = 0; i < SETS; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
            hitCnt    <= {CNT_W{1'b0}};
            missCnt   <= {CNT_W{1'b0}};
            ready     <= 1'b0;
            hold      <= 1'b0;
            memRd     <= 1'b0;
            memWr     <= 1'b0;
            memRowId  <= {ROW_BITS{1'b0}};
            cRowId    <= {IDX_W{1'b0}};
            flushDone <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            req_row_r <= req_row_next_s;
            req_rd_r  <= req_rd_next_s;
            ptr_r     <= ptr_next_s;

            if (new_req_s) begin
                missed_r <= 1'b0;
            end else if (miss_evt_s) begin
                missed_r <= 1'b1;
            end else begin
                missed_r <= missed_r;
            end

            if (set_dirty_s) begin
                dirty_r[req_idx_s] <= 1'b1;
            end else if (wb_done_s || fill_s) begin
                dirty_r[req_idx_s] <= 1'b0;
            end else if (flush_clr_s) begin
                dirty_r[ptr_r] <= 1'b0;
            end else begin
                dirty_r <= dirty_r;
            end

            if (fill_s) begin
                valid_r[req_idx_s] <= 1'b1;
                tag_r[req_idx_s]   <= req_tag_s;
            end

            if (miss_evt_s && (missCnt != CNT_MAX)) begin
                missCnt <= missCnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (hit_evt_s && !missed_r && (hitCnt != CNT_MAX)) begin
                hitCnt <= hitCnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            ready     <= ready_s;
            hold      <= hold_s;
            memRd     <= mem_rd_s;
            memWr     <= mem_wr_s;
            memRowId  <= mem_row_s;
            cRowId    <= c_row_s;
            flushDone <= flush_done_s;
        end
    end

endmodule

// File: tb/tb_row_cache_ctrl.sv
// Scoreboard bench for row_cache_ctrl: directed requests push the expected
// memory/ready/flush events; a negedge monitor pops and compares them.
module tb_row_cache_ctrl;

    localparam int ROW_BITS = 17;
    localparam int SETS     = 32;
    localparam int CNT_W    = 16;
    localparam int IDX_W    = 5;

    localparam logic [1:0] K_READY = 2'd0;
    localparam logic [1:0] K_MEMRD = 2'd1;
    localparam logic [1:0] K_MEMWR = 2'd2;
    localparam logic [1:0] K_FDONE = 2'd3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                RD = 1'b0;
    logic                WR = 1'b0;
    logic [ROW_BITS-1:0] RowId = '0;
    logic                sync = 1'b0;
    logic                flush = 1'b0;
    logic [IDX_W-1:0]    cRowId;
    logic                ready, hold, memRd, memWr, flushDone;
    logic [ROW_BITS-1:0] memRowId;
    logic [CNT_W-1:0]    hitCnt, missCnt;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;

    ev_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    logic p_ready = 1'b0, p_rd = 1'b0, p_wr = 1'b0;

    row_cache_ctrl #(.ROW_BITS(ROW_BITS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .RD(RD), .WR(WR), .RowId(RowId),
        .sync(sync), .flush(flush), .cRowId(cRowId), .ready(ready),
        .hold(hold), .memRd(memRd), .memWr(memWr), .memRowId(memRowId),
        .flushDone(flushDone), .hitCnt(hitCnt), .missCnt(missCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [1:0] kind, input logic [31:0] val);
        ev_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d val 0x%0h expected no event", kind, val);
        end else begin
            e = sb_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                errors++;
                $display("FAIL sb_event: got kind %0d val 0x%0h expected kind %0d val 0x%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every rising output event
    always @(negedge clk) begin
        if (rst) begin
            if (ready && !p_ready) sb_check(K_READY, {27'd0, cRowId});
            if (memRd && !p_rd) begin
                sb_check(K_MEMRD, {15'd0, memRowId});
                chk("hold_on_memRd", {31'd0, hold}, 32'd1);
            end
            if (memWr && !p_wr) begin
                sb_check(K_MEMWR, {15'd0, memRowId});
                chk("hold_on_memWr", {31'd0, hold}, 32'd1);
            end
            if (flushDone) sb_check(K_FDONE, 32'd0);
        end
        p_ready <= ready;
        p_rd    <= memRd;
        p_wr    <= memWr;
    end

    // Issue one request, answer memory with sync, wait for ready, then release
    task automatic do_req(input logic rd, input logic wr, input logic [ROW_BITS-1:0] row,
                          output int cycles);
        int n;
        @(negedge clk);
        RD = rd; WR = wr; RowId = row;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (ready) break;
            sync = memRd | memWr;
        end
        sync = 1'b0;
        cycles = n;
        if (!ready) chk("req_timeout", 32'd0, 32'd1);
        RD = 1'b0; WR = 1'b0;
        @(negedge clk);
    endtask

    // Flush the cache, answering write-backs, and check flushDone is one cycle
    task automatic do_flush();
        int n;
        logic seen;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (flushDone) begin
                seen = 1'b1;
                break;
            end
            sync = memWr;
        end
        sync = 1'b0;
        chk("flush_done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("flush_done_one_cycle", {31'd0, flushDone}, 32'd0);
        chk("flush_idle_hold", {31'd0, hold}, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_hold", {31'd0, hold}, 32'd0);
        chk("rst_memRd", {31'd0, memRd}, 32'd0);
        chk("rst_cnts", {hitCnt, missCnt}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // First read misses, allocates, then hits from the refill
        expect_ev(K_MEMRD, 32'h00025);
        expect_ev(K_READY, 32'd5);
        do_req(1'b1, 1'b0, 17'h00025, cyc);
        chk("t1_missCnt", {16'd0, missCnt}, 32'd1);
        chk("t1_hitCnt", {16'd0, hitCnt}, 32'd0);

        // Repeat read hits with two-edge latency
        expect_ev(K_READY, 32'd5);
        do_req(1'b1, 1'b0, 17'h00025, cyc);
        chk("t2_latency", cyc, 32'd2);
        chk("t2_hitCnt", {16'd0, hitCnt}, 32'd1);
        chk("t2_missCnt", {16'd0, missCnt}, 32'd1);

        // Write hit dirties idx 5; conflicting read writes it back first
        expect_ev(K_READY, 32'd5);
        do_req(1'b0, 1'b1, 17'h00025, cyc);
        chk("t3_hitCnt", {16'd0, hitCnt}, 32'd2);
        expect_ev(K_MEMWR, 32'h00025);
        expect_ev(K_MEMRD, 32'h00045);
        expect_ev(K_READY, 32'd5);
        do_req(1'b1, 1'b0, 17'h00045, cyc);
        chk("t3_missCnt", {16'd0, missCnt}, 32'd2);
        chk("t3_hitCnt_after_miss", {16'd0, hitCnt}, 32'd2);

        // Dirty idx 3 and 7, then flush writes back exactly those two
        expect_ev(K_MEMRD, 32'h00003);
        expect_ev(K_READY, 32'd3);
        do_req(1'b0, 1'b1, 17'h00003, cyc);
        expect_ev(K_MEMRD, 32'h00007);
        expect_ev(K_READY, 32'd7);
        do_req(1'b0, 1'b1, 17'h00007, cyc);
        chk("t4_missCnt", {16'd0, missCnt}, 32'd4);
        expect_ev(K_MEMWR, 32'h00003);
        expect_ev(K_MEMWR, 32'h00007);
        expect_ev(K_FDONE, 32'd0);
        do_flush();
        // All entries clean now: second flush writes nothing back
        expect_ev(K_FDONE, 32'd0);
        do_flush();

        // Reset in the middle of Allocate
        expect_ev(K_MEMRD, 32'h00011);
        @(negedge clk);
        RD = 1'b1; RowId = 17'h00011;
        repeat (2) @(negedge clk);
        chk("t5_in_alloc", {31'd0, memRd}, 32'd1);
        chk("t5_missCnt", {16'd0, missCnt}, 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_memRd", {31'd0, memRd}, 32'd0);
        chk("t5_rst_hold", {31'd0, hold}, 32'd0);
        chk("t5_rst_memRowId", {15'd0, memRowId}, 32'd0);
        chk("t5_rst_cRowId", {27'd0, cRowId}, 32'd0);
        chk("t5_rst_cnts", {hitCnt, missCnt}, 32'd0);
        RD = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // First request after reset misses; RD and WR both high acts as read
        expect_ev(K_MEMRD, 32'h00003);
        expect_ev(K_READY, 32'd3);
        do_req(1'b1, 1'b1, 17'h00003, cyc);
        chk("t6_missCnt", {16'd0, missCnt}, 32'd1);
        chk("t6_hitCnt", {16'd0, hitCnt}, 32'd0);
        expect_ev(K_READY, 32'd3);
        do_req(1'b1, 1'b1, 17'h00003, cyc);
        chk("t6_hit_latency", cyc, 32'd2);
        chk("t6_hitCnt2", {16'd0, hitCnt}, 32'd1);
        // Read-treated requests leave nothing dirty
        expect_ev(K_FDONE, 32'd0);
        do_flush();

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
